serial_digit_adder: RTL and testbench

//   Multi-cycle add/subtract unit: adds two WIDTH-bit operands DIGIT bits per clock,

---
 rtl/serial_digit_adder.sv | 123 ++++++++++++
 tb/tb_serial_digit_adder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract: one DIGIT-wide ripple slice with a registered carry,
// iterated WIDTH/DIGIT times between a valid/ready input and a valid/ready output.
module serial_digit_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, sum_reg;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]    cnt_reg;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic             last_digit;

  // Ripple slice over the low digit of the operand shift registers.
  assign c[0] = carry_reg;
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
    assign dsum[gi]  = a_reg[gi] ^ b_reg[gi] ^ c[gi];
    assign c[gi + 1] = (a_reg[gi] & b_reg[gi]) | (c[gi] & (a_reg[gi] ^ b_reg[gi]));
  end

  // New digit enters at the MSB end so the full word is aligned after CYCLES shifts.
  assign acc_next   = (acc_reg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last_digit = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (state_reg == IDLE && !rst) in_ready = 1'b1;
    if (state_reg == DONE)         out_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= cin ^ sub;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          carry_reg <= c[DIGIT];
          acc_reg   <= acc_next;
          if (last_digit) begin
            // Visible result only changes here, so it holds through the next RUN.
            sum_reg  <= acc_next;
            cout_reg <= c[DIGIT];
            ovf_reg  <= c[DIGIT] ^ c[DIGIT-1];
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder: directed cases on DIGIT=4 plus
// concurrent randomized runs on DIGIT=4, 1 and 32 against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_digit_adder;

  localparam int N = 3;

  function automatic int dig_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
  endfunction

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  localparam vec_t VEC [6] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
    '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0},
    '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [N];
  logic        in_ready [N];
  logic        cin [N];
  logic        sub [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic        cout [N];
  logic        ovf [N];
  logic [31:0] a [N];
  logic [31:0] b [N];
  logic [31:0] sum [N];

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb0[$];
  logic [31:0] held_sum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    serial_digit_adder #(.WIDTH(32), .DIGIT(dig_of(gi))) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .a        (a[gi]),
      .b        (b[gi]),
      .cin      (cin[gi]),
      .sub      (sub[gi]),
      .out_valid(out_valid[gi]),
      .out_ready(out_ready[gi]),
      .sum      (sum[gi]),
      .cout     (cout[gi]),
      .ovf      (ovf[gi])
    );
  end

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    exp_t        e;
    logic [31:0] yy;
    logic [32:0] full;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + {32'd0, ci ^ s};
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (x[31] == yy[31]) && (e.sum[31] != x[31]);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Presents one operation; returns the cycle index of the accepting edge.
  task automatic start_op(input int k, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, output int acc);
    int w = 0;
    @(negedge clk);
    while (in_ready[k] !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (in_ready[k] !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready k=%0d got=%b want=1", k, in_ready[k]);
    end
    a[k] = x; b[k] = y; cin[k] = ci; sub[k] = s; in_valid[k] = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    a[k] = $urandom; b[k] = $urandom;
    cin[k] = 1'($urandom_range(0, 1)); sub[k] = 1'($urandom_range(0, 1));
  endtask

  // Returns the cycle index at which out_valid is first seen, or -1 on timeout.
  task automatic wait_valid(input int k, output int seen);
    int w = 0;
    while (out_valid[k] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    seen = (out_valid[k] === 1'b1) ? cyc : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      total++;
      if (in_ready[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_in_ready_during k=%0d got=%b want=0", k, in_ready[k]);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      total++;
      if ({in_ready[k], out_valid[k], sum[k], cout[k], ovf[k]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_state k=%0d got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
                 k, in_ready[k], out_valid[k], sum[k], cout[k], ovf[k]);
      end
    end
    $display("reset k=0 rdy=%b vld=%b sum=%h", in_ready[0], out_valid[0], sum[0]);
  endtask

  task automatic test_arith();
    int   acc, seen;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.sum = VEC[i].s; e.cout = VEC[i].co; e.ovf = VEC[i].ov;
      start_op(0, VEC[i].a, VEC[i].b, VEC[i].cin, VEC[i].sub, acc);
      e.acc_cyc = acc;
      sb0.push_back(e);
      wait_valid(0, seen);
      e = sb0.pop_front();
      total++;
      if (seen - e.acc_cyc != 8) begin
        bad++;
        $display("FAIL arith_latency v=%0d got=%0d want=8", i, seen - e.acc_cyc);
      end
      total++;
      if (sum[0] !== e.sum) begin
        bad++;
        $display("FAIL arith_sum v=%0d got=%h want=%h", i, sum[0], e.sum);
      end
      total++;
      if ({cout[0], ovf[0]} !== {e.cout, e.ovf}) begin
        bad++;
        $display("FAIL arith_flags v=%0d got cout=%b ovf=%b want cout=%b ovf=%b",
                 i, cout[0], ovf[0], e.cout, e.ovf);
      end
      $display("op v=%0d a=%h b=%h cin=%b sub=%b sum=%h cout=%b ovf=%b lat=%0d",
               i, VEC[i].a, VEC[i].b, VEC[i].cin, VEC[i].sub, sum[0], cout[0], ovf[0], seen - e.acc_cyc);
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      total++;
      if ({out_valid[0], in_ready[0]} !== 2'b01) begin
        bad++;
        $display("FAIL arith_release v=%0d got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid[0], in_ready[0]);
      end
    end
  endtask

  task automatic test_stall();
    int   acc, seen;
    exp_t e;
    e = model(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    start_op(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0, acc);
    e.acc_cyc = acc;
    sb0.push_back(e);
    wait_valid(0, seen);
    e = sb0.pop_front();
    total++;
    if (seen - e.acc_cyc != 8) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=8", seen - e.acc_cyc);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid[0], in_ready[0], sum[0], cout[0], ovf[0]} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
        bad++;
        $display("FAIL stall_hold i=%0d got vld=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                 i, out_valid[0], in_ready[0], sum[0], cout[0], ovf[0], e.sum, e.cout, e.ovf);
      end
      in_valid[0] = 1'($urandom_range(0, 1));
      a[0] = $urandom;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    total++;
    if ({out_valid[0], in_ready[0], sum[0]} !== {1'b0, 1'b1, e.sum}) begin
      bad++;
      $display("FAIL stall_release got vld=%b rdy=%b sum=%h want 0 1 %h", out_valid[0], in_ready[0], sum[0], e.sum);
    end
    held_sum = e.sum;
    $display("op stall sum=%h cout=%b ovf=%b lat=%0d", sum[0], cout[0], ovf[0], seen - e.acc_cyc);
  endtask

  task automatic test_rst_abort();
    int   acc, seen;
    int   early;
    exp_t e;
    start_op(0, 32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, acc);
    total++;
    if (sum[0] !== held_sum) begin
      bad++;
      $display("FAIL run_hold_sum got=%h want=%h", sum[0], held_sum);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid[0], in_ready[0], sum[0], cout[0], ovf[0]} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_state got vld=%b rdy=%b sum=%h cout=%b ovf=%b want 0 1 0 0 0",
               out_valid[0], in_ready[0], sum[0], cout[0], ovf[0]);
    end
    early = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL abort_no_result got=%0d valid cycles want=0", early);
    end
    e = model(32'd3, 32'd4, 1'b0, 1'b0);
    start_op(0, 32'd3, 32'd4, 1'b0, 1'b0, acc);
    e.acc_cyc = acc;
    sb0.push_back(e);
    wait_valid(0, seen);
    e = sb0.pop_front();
    total++;
    if (seen - e.acc_cyc != 8 || sum[0] !== 32'd7) begin
      bad++;
      $display("FAIL abort_fresh got sum=%h lat=%0d want sum=00000007 lat=8", sum[0], seen - e.acc_cyc);
    end
    $display("op fresh a=3 b=4 sum=%h lat=%0d", sum[0], seen - e.acc_cyc);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic run_random(input int k, input int nops);
    exp_t        q[$];
    exp_t        e;
    int          acc, seen, lat;
    int          want_lat;
    logic [31:0] ra, rb;
    logic        rc, rs;
    want_lat = 32 / dig_of(k);
    for (int n = 0; n < nops; n++) begin
      ra = $urandom; rb = $urandom;
      if (n % 8 == 0) ra = 32'h7FFFFFFF;
      if (n % 8 == 4) rb = 32'h80000000;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      e = model(ra, rb, rc, rs);
      start_op(k, ra, rb, rc, rs, acc);
      e.acc_cyc = acc;
      q.push_back(e);
      wait_valid(k, seen);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      e = q.pop_front();
      lat = seen - e.acc_cyc;
      total++;
      if (lat != want_lat) begin
        bad++;
        $display("FAIL rand_latency k=%0d n=%0d got=%0d want=%0d", k, n, lat, want_lat);
      end
      total++;
      if ({out_valid[k], sum[k], cout[k], ovf[k]} !== {1'b1, e.sum, e.cout, e.ovf}) begin
        bad++;
        $display("FAIL rand_result k=%0d n=%0d a=%h b=%h cin=%b sub=%b got vld=%b sum=%h cout=%b ovf=%b want 1 %h %b %b",
                 k, n, ra, rb, rc, rs, out_valid[k], sum[k], cout[k], ovf[k], e.sum, e.cout, e.ovf);
      end
      $display("op digit=%0d n=%0d a=%h b=%h cin=%b sub=%b sum=%h cout=%b ovf=%b lat=%0d",
               dig_of(k), n, ra, rb, rc, rs, sum[k], cout[k], ovf[k], lat);
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
    end
  endtask

  task automatic test_random();
    fork
      run_random(0, 1000);
      run_random(1, 1000);
      run_random(2, 1000);
    join
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      a[k]   = '0;
      b[k]   = '0;
      cin[k] = 1'b0;
      sub[k] = 1'b0;
    end
    held_sum = '0;
    rst = 1'b1;
    test_reset();
    test_arith();
    test_stall();
    test_rst_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
